melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Programmable note sequencer that drives the sine/DAC tone path. It holds a writable note table of pitch and duration entries and steps through it on the 8 kHz sample tick (`fs_clk` from the fs clkgen). It presents the current clkgen maxval (`pitch`), a gate for articulation, and a one-cycle `note_start` pulse so the sine clkgen can be restarted at each note boundary. It replaces hard-coded melody arrays with a run-time-loaded table and start/stop/loop control.

## Interface
- `DEPTH`, 32: number of note table entries.
- `AW`, 5: table address width; DEPTH = 2**AW.
- `PW`, 5: pitch width, which is the clkgen maxval width.
- `DW`, 13: duration width, counted in ticks.
- `GAP`, 1: ticks of silence (gate low) at the end of each note.

- `clk`  in  1  system clock (1 MHz).
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  one-cycle sample-rate strobe (fs_clk).
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_pitch`  in  PW  pitch to write; 0 means rest.
- `wr_dur`  in  DW  duration in ticks; 0 is treated as 1.
- `last_idx`  in  AW  index of the final note; sampled on an accepted start.
- `loop`  in  1  wrap to entry 0 after `last_idx`; sampled continuously.
- `start`  in  1  one-cycle start request.
- `stop`  in  1  one-cycle abort request.
- `busy`  out  1  high when the state is not IDLE.
- `pitch`  out  PW  current note maxval; 0 while a rest is playing or in IDLE.
- `gate`  out  1  high when the tone is audible.
- `note_start`  out  1  one-cycle pulse on the first PLAY cycle of every note.
- `done`  out  1  one-cycle pulse when a non-loop sequence finishes.
- `cur_idx`  out  AW  index of the note being played.

## Operation
- **Table storage.** The table is synchronous-read RAM, DEPTH x (PW+DW).
  - Writes are accepted only in IDLE.
  - `wr_en` while `busy` is dropped; the table is unchanged.
- **States.** IDLE, FETCH, PLAY.
- **IDLE.**
  - Outputs: `pitch`=0, `gate`=0, `cur_idx` holds its last value.
  - `start` (with no `stop` in the same cycle): latch `last_idx`, set idx=0, go to FETCH.
- **FETCH.**
  - Lasts exactly 1 cycle; RAM read of entry idx.
  - `gate`=0; `pitch` holds the previous value.
  - Ticks in FETCH are ignored.
  - Go to PLAY.
- **PLAY entry.**
  - Load `pitch` and dur from the RAM output; dur = max(wr_dur, 1).
  - Set dur_ctr=0, `cur_idx`=idx, and pulse `note_start`.
- **PLAY, each tick.**
  - If dur_ctr == dur-1, the note ends:
    - if idx != last_idx_q: idx+1, go to FETCH;
    - else if `loop`: idx=0, go to FETCH;
    - else: pulse `done`, go to IDLE.
  - Otherwise dur_ctr+1.
- **Gate rule.**
  - In PLAY: `gate` = (`pitch` != 0) && (dur_ctr < dur - GAP).
  - If dur <= GAP, `gate` stays 0 for the whole note.
  - dur - GAP is computed at DW+1 bits, signed-safe; it must not wrap.
- **Stop.**
  - `stop` in any state: go to IDLE the next cycle with `gate`=0 and `pitch`=0.
  - No `done` pulse.
  - `stop` and `start` in the same cycle: `stop` wins.
- **Other boundaries.**
  - `start` while `busy` is ignored.
  - idx increments modulo DEPTH; `last_idx` = DEPTH-1 is legal.
  - `reset` mid-note: all state is cleared next edge. The table contents are not cleared.

## Timing
- **Reset values.** state=IDLE, `busy`=0, `pitch`=0, `gate`=0, `note_start`=0, `done`=0, `cur_idx`=0, dur_ctr=0.
- **Start.** `start` sampled at edge T:
  - FETCH during T+1;
  - PLAY from T+2, with `pitch`, `gate` and `note_start` valid at T+2.
- **Note length.** A note spans exactly dur ticks.
  - The ending tick at cycle E gives FETCH at E+1 and the next note's `note_start` at E+2.
- **Done.** `done` is asserted in the cycle after the final ending tick, coincident with `busy` falling.
- **Registered outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Basic three-note run.**
  - Stimulus: write {7,3},{13,2},{18,1}; `last_idx`=2; `loop`=0; GAP=1; tick every 4 cycles; `start`.
  - Required: `pitch` 7→13→18.
  - Required: `note_start` ×3.
  - Required: `gate` high for 2, 1 and 0 ticks respectively.
  - Required: one `done`, then `busy`=0 and `pitch`=0.
- **Loop.**
  - Stimulus: same table with `loop`=1, run for 20 ticks.
  - Required: after 18 the sequence wraps to 7, `cur_idx` goes 2→0, and `done` never pulses.
  - Stimulus: drop `loop` to 0.
  - Required: the run ends after the next index-2 note.
- **Stop mid-note.**
  - Stimulus: assert `stop` during the 2nd tick of note 0.
  - Required: next cycle `busy`=0, `gate`=0, `pitch`=0, and no `done`.
  - Stimulus: assert `start` and `stop` together.
  - Required: the block stays in IDLE.
- **Rest and zero duration.**
  - Stimulus: entry {0,4} followed by entry {21,0}.
  - Required: `pitch`=0 with `gate`=0 for 4 ticks.
  - Required: then `pitch`=21 for exactly 1 tick with `gate`=0 (dur=1 <= GAP).
- **Writes while busy and start while busy.**
  - Stimulus: during PLAY, write pitch 27 to entry 1 and pulse `start`.
  - Required: entry 1 still plays its old value and the sequence does not restart.
  - Required: after IDLE, a rewrite of entry 1 takes effect.
- **Reset mid-run.**
  - Stimulus: assert `reset` in PLAY.
  - Required: all outputs reach their reset values next edge.
  - Required: a subsequent `start` replays the table unchanged.

Source files
------------

// File: rtl/melody_sequencer.sv
// Purpose: run-time programmable note sequencer feeding the sine clkgen with pitch, gate and note_start.
// Latency: start -> first note_start 2 cycles; ending tick -> next note_start 2 cycles; all outputs registered.
// Backpressure: none; table writes and start requests arriving while busy are dropped, stop always wins.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   tick                        one-cycle sample-rate strobe that advances note timing
//   wr_en/wr_addr/wr_pitch/wr_dur  note table write port (accepted only while idle)
//   last_idx, loop              final note index (latched at start) and wrap enable (live)
//   start, stop                 one-cycle run / abort requests
//   busy, pitch, gate, note_start, done, cur_idx  registered playback status and tone controls
module melody_sequencer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int PW    = 5,
    parameter int DW    = 13,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_pitch,
    input  logic [DW-1:0] wr_dur,
    input  logic [AW-1:0] last_idx,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [PW-1:0] pitch,
    output logic          gate,
    output logic          note_start,
    output logic          done,
    output logic [AW-1:0] cur_idx
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    typedef struct packed {
        logic [PW-1:0] pitch;
        logic [DW-1:0] dur;
    } note_t;

    localparam int                    DW2   = DW + 2;
    localparam logic signed [DW+1:0]  GAP_S = DW2'(GAP);

    // Gate is high while the counter is below dur-GAP. The limit is formed two
    // bits wider and signed so that dur <= GAP yields a non-positive limit
    // (gate never opens) instead of wrapping to a large unsigned value.
    function automatic logic gate_on(input logic [PW-1:0] p,
                                     input logic [DW-1:0] ctr,
                                     input logic [DW-1:0] d);
        logic signed [DW+1:0] lim;
        lim = $signed({2'b00, d}) - GAP_S;
        return (p != '0) && ($signed({2'b00, ctr}) < lim);
    endfunction

    note_t         mem [DEPTH];
    note_t         rd_q;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [DW-1:0] dur_ctr_q, dur_ctr_d;
    logic [PW-1:0] pitch_q, pitch_d;
    logic          gate_q, gate_d;
    logic          note_start_q, note_start_d;
    logic          done_q, done_d;
    logic [AW-1:0] cur_idx_q, cur_idx_d;
    logic          busy_q;
    logic [DW-1:0] fetch_dur;
    logic          wr_ok;

    assign wr_ok     = wr_en && (state_q == IDLE);
    // A zero duration plays as a single tick.
    assign fetch_dur = (rd_q.dur == '0) ? DW'(1) : rd_q.dur;

    // Table RAM. The read address is the next-cycle index, so the entry chosen
    // on the way into FETCH is already sitting in rd_q during FETCH and can be
    // loaded into the output registers on the FETCH->PLAY edge. A write to the
    // address being read in the same cycle is forwarded so a table load in the
    // start cycle is not missed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= {wr_pitch, wr_dur};
        end
        if (wr_ok && (wr_addr == idx_d)) begin
            rd_q <= {wr_pitch, wr_dur};
        end else begin
            rd_q <= mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            dur_q        <= '0;
            dur_ctr_q    <= '0;
            pitch_q      <= '0;
            gate_q       <= 1'b0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
            cur_idx_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            dur_q        <= dur_d;
            dur_ctr_q    <= dur_ctr_d;
            pitch_q      <= pitch_d;
            gate_q       <= gate_d;
            note_start_q <= note_start_d;
            done_q       <= done_d;
            cur_idx_q    <= cur_idx_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_d       = last_q;
        dur_d        = dur_q;
        dur_ctr_d    = dur_ctr_q;
        pitch_d      = pitch_q;
        gate_d       = gate_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;
        cur_idx_d    = cur_idx_q;

        case (state_q)
            IDLE: begin
                pitch_d = '0;
                gate_d  = 1'b0;
                if (start && !stop) begin
                    last_d  = last_idx;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                state_d      = PLAY;
                pitch_d      = rd_q.pitch;
                dur_d        = fetch_dur;
                dur_ctr_d    = '0;
                cur_idx_d    = idx_q;
                note_start_d = 1'b1;
                gate_d       = gate_on(rd_q.pitch, '0, fetch_dur);
            end

            PLAY: begin
                if (tick) begin
                    if (dur_ctr_q == (dur_q - DW'(1))) begin
                        // Silence through the FETCH cycle; pitch holds until the next note loads.
                        gate_d = 1'b0;
                        if (idx_q != last_q) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = FETCH;
                        end else if (loop) begin
                            idx_d   = '0;
                            state_d = FETCH;
                        end else begin
                            done_d  = 1'b1;
                            pitch_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        dur_ctr_d = dur_ctr_q + DW'(1);
                        gate_d    = gate_on(pitch_q, dur_ctr_q + DW'(1), dur_q);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (stop) begin
            state_d      = IDLE;
            pitch_d      = '0;
            gate_d       = 1'b0;
            note_start_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    assign busy       = busy_q;
    assign pitch      = pitch_q;
    assign gate       = gate_q;
    assign note_start = note_start_q;
    assign done       = done_q;
    assign cur_idx    = cur_idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Purpose: self-checking bench for melody_sequencer with a note scoreboard.
// Latency: checks start->note_start timing and per-note tick/gate counts.
// Backpressure: exercises dropped writes/starts while busy, stop, and reset aborts.
module tb_melody_sequencer;

    localparam int AW  = 5;
    localparam int PW  = 5;
    localparam int DW  = 13;
    localparam int GAP = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_pitch = '0;
    logic [DW-1:0] wr_dur = '0;
    logic [AW-1:0] last_idx = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic [PW-1:0] pitch;
    logic          gate;
    logic          note_start;
    logic          done;
    logic [AW-1:0] cur_idx;

    melody_sequencer #(.DEPTH(32), .AW(AW), .PW(PW), .DW(DW), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_dur(wr_dur),
        .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
        .busy(busy), .pitch(pitch), .gate(gate), .note_start(note_start),
        .done(done), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pitch;
        int idx;
        int len;
        int gate_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   notes_seen = 0;
    int   done_c = 0;
    bit   open = 0;
    int   cur_p, cur_i, len_c, gate_c;

    // Sample-rate strobe: one cycle high every 4 clocks.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    function automatic int exp_gate(int p, int d);
        int dd;
        dd = (d == 0) ? 1 : d;
        if (p == 0 || dd <= GAP) return 0;
        return dd - GAP;
    endfunction

    task automatic push_note(int p, int i, int d);
        exp_t e;
        e.pitch  = p;
        e.idx    = i;
        e.len    = (d == 0) ? 1 : d;
        e.gate_n = exp_gate(p, d);
        exp_q.push_back(e);
    endtask

    task automatic push_partial(int p, int i, int len, int gn);
        exp_t e;
        e.pitch  = p;
        e.idx    = i;
        e.len    = len;
        e.gate_n = gn;
        exp_q.push_back(e);
    endtask

    // Note monitor: a note opens on note_start and closes at the next
    // note_start or when busy drops; its ticks and gated ticks are then
    // compared against the front of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (open && (note_start || !busy)) begin
                open = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL note_unexpected: got pitch=%0d idx=%0d, required no note", cur_p, cur_i);
                end else begin
                    m_e = exp_q.pop_front();
                    checks += 4;
                    if (cur_p !== m_e.pitch) begin
                        errors++;
                        $display("FAIL note_pitch: got %0d, required %0d", cur_p, m_e.pitch);
                    end
                    if (cur_i !== m_e.idx) begin
                        errors++;
                        $display("FAIL note_idx: got %0d, required %0d (pitch %0d)", cur_i, m_e.idx, m_e.pitch);
                    end
                    if (len_c !== m_e.len) begin
                        errors++;
                        $display("FAIL note_ticks: got %0d, required %0d (pitch %0d)", len_c, m_e.len, m_e.pitch);
                    end
                    if (gate_c !== m_e.gate_n) begin
                        errors++;
                        $display("FAIL note_gate_ticks: got %0d, required %0d (pitch %0d)", gate_c, m_e.gate_n, m_e.pitch);
                    end
                end
            end
            if (note_start) begin
                open = 1;
                notes_seen++;
                cur_p  = int'(pitch);
                cur_i  = int'(cur_idx);
                len_c  = 0;
                gate_c = 0;
            end
            if (open && busy && tick) begin
                len_c++;
                if (gate) gate_c++;
            end
            if (done) done_c++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_note(int a, int p, int d);
        cyc();
        wr_en    = 1'b1;
        wr_addr  = AW'(a);
        wr_pitch = PW'(p);
        wr_dur   = DW'(d);
        cyc();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_start();
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_notes(int target, int budget, string name);
        bit hit;
        hit = 0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(posedge clk);
            #2;
            if (notes_seen >= target) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s_wait_notes: got %0d notes, required %0d", name, notes_seen, target);
        end
    endtask

    task automatic wait_idle(int budget, string name);
        bit hit;
        hit = 0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(posedge clk);
            #2;
            if (!busy) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s_wait_idle: busy still %0b after %0d cycles, required 0", name, busy, budget);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_queue(string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_notes_missing: got %0d unplayed, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(string name);
        checks += 6;
        if (busy !== 1'b0)       begin errors++; $display("FAIL %s_busy: got %0b, required 0", name, busy); end
        if (pitch !== '0)        begin errors++; $display("FAIL %s_pitch: got %0d, required 0", name, pitch); end
        if (gate !== 1'b0)       begin errors++; $display("FAIL %s_gate: got %0b, required 0", name, gate); end
        if (note_start !== 1'b0) begin errors++; $display("FAIL %s_note_start: got %0b, required 0", name, note_start); end
        if (done !== 1'b0)       begin errors++; $display("FAIL %s_done: got %0b, required 0", name, done); end
        if (cur_idx !== '0)      begin errors++; $display("FAIL %s_cur_idx: got %0d, required 0", name, cur_idx); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_c;
        last_idx = 2;
        loop = 1'b0;
        push_note(7, 0, 3);
        push_note(13, 1, 2);
        push_note(18, 2, 1);
        pulse_start();
        // Now in the FETCH cycle (T+1).
        checks += 3;
        if (busy !== 1'b1)       begin errors++; $display("FAIL basic_fetch_busy: got %0b, required 1", busy); end
        if (note_start !== 1'b0) begin errors++; $display("FAIL basic_fetch_note_start: got %0b, required 0", note_start); end
        if (gate !== 1'b0)       begin errors++; $display("FAIL basic_fetch_gate: got %0b, required 0", gate); end
        cyc();
        checks += 2;
        if (note_start !== 1'b1) begin errors++; $display("FAIL basic_first_note_start: got %0b, required 1", note_start); end
        if (pitch !== PW'(7))    begin errors++; $display("FAIL basic_first_pitch: got %0d, required 7", pitch); end
        wait_idle(300, "basic");
        checks += 3;
        if (done_c - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_c - d0); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_end: got %0b, required 0", busy); end
        if (pitch !== '0)      begin errors++; $display("FAIL basic_pitch_end: got %0d, required 0", pitch); end
        check_queue("basic");
    endtask

    task automatic test_loop();
        int d0, base;
        d0 = done_c;
        base = notes_seen;
        last_idx = 2;
        loop = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_note(7, 0, 3);
            push_note(13, 1, 2);
            push_note(18, 2, 1);
        end
        pulse_start();
        wait_notes(base + 7, 400, "loop");
        checks++;
        if (done_c !== d0) begin errors++; $display("FAIL loop_no_done: got %0d pulses, required 0", done_c - d0); end
        loop = 1'b0;
        wait_idle(400, "loop");
        checks++;
        if (done_c - d0 !== 1) begin errors++; $display("FAIL loop_done_count: got %0d, required 1", done_c - d0); end
        check_queue("loop");
    endtask

    task automatic test_stop();
        int d0, n;
        d0 = done_c;
        last_idx = 2;
        push_partial(7, 0, 2, 2);
        pulse_start();
        n = 0;
        while (!(open && len_c >= 1) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        while (!tick && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL stop_find_tick: got timeout, required second tick"); end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks += 3;
        if (busy !== 1'b0)  begin errors++; $display("FAIL stop_busy: got %0b, required 0", busy); end
        if (gate !== 1'b0)  begin errors++; $display("FAIL stop_gate: got %0b, required 0", gate); end
        if (pitch !== '0)   begin errors++; $display("FAIL stop_pitch: got %0d, required 0", pitch); end
        @(negedge clk);
        #1;
        checks++;
        if (done_c !== d0) begin errors++; $display("FAIL stop_no_done: got %0d pulses, required 0", done_c - d0); end
        check_queue("stop");
        // start and stop together: stop wins, nothing runs.
        cyc();
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %0b, required 0", busy); end
        repeat (3) cyc();
        checks += 2;
        if (busy !== 1'b0)       begin errors++; $display("FAIL start_stop_busy_later: got %0b, required 0", busy); end
        if (note_start !== 1'b0) begin errors++; $display("FAIL start_stop_note_start: got %0b, required 0", note_start); end
    endtask

    task automatic test_rest_zero();
        int d0;
        d0 = done_c;
        write_note(0, 0, 4);
        write_note(1, 21, 0);
        last_idx = 1;
        push_note(0, 0, 4);
        push_note(21, 1, 0);
        pulse_start();
        wait_idle(300, "rest");
        checks++;
        if (done_c - d0 !== 1) begin errors++; $display("FAIL rest_done_count: got %0d, required 1", done_c - d0); end
        check_queue("rest");
        write_note(0, 7, 3);
        write_note(1, 13, 2);
    endtask

    task automatic test_busy_write();
        int base;
        last_idx = 2;
        base = notes_seen;
        push_note(7, 0, 3);
        push_note(13, 1, 2);
        push_note(18, 2, 1);
        pulse_start();
        wait_notes(base + 1, 100, "busy_write");
        cyc();
        wr_en    = 1'b1;
        wr_addr  = 1;
        wr_pitch = 27;
        wr_dur   = 2;
        start    = 1'b1;
        cyc();
        wr_en = 1'b0;
        start = 1'b0;
        wait_idle(300, "busy_write");
        check_queue("busy_write");
        write_note(1, 27, 2);
        push_note(7, 0, 3);
        push_note(27, 1, 2);
        push_note(18, 2, 1);
        pulse_start();
        wait_idle(300, "rewrite");
        check_queue("rewrite");
        write_note(1, 13, 2);
    endtask

    task automatic test_reset_mid();
        int base, d0;
        last_idx = 2;
        base = notes_seen;
        push_note(7, 0, 3);
        push_partial(13, 1, 0, 0);
        pulse_start();
        wait_notes(base + 2, 200, "reset_mid");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        #1;
        check_queue("reset_mid");
        d0 = done_c;
        push_note(7, 0, 3);
        push_note(13, 1, 2);
        push_note(18, 2, 1);
        pulse_start();
        wait_idle(300, "replay");
        checks++;
        if (done_c - d0 !== 1) begin errors++; $display("FAIL replay_done_count: got %0d, required 1", done_c - d0); end
        check_queue("replay");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        write_note(0, 7, 3);
        write_note(1, 13, 2);
        write_note(2, 18, 1);
        test_basic();
        test_loop();
        test_stop();
        test_rest_zero();
        test_busy_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
